load_store_control: RTL and testbench
=====================================

LOAD_STORE_CONTROL -- requirements
Module: load_store_control

Interface
REQ-001 SHALL have no parameters; all timing is fixed by the state machine below.
REQ-002 clock  in  1  system clock; all state changes on rising edge.
REQ-003 clear  in  1  reset, asynchronous, active-high.
REQ-004 ir_opcode  in  5  IR[31:27] from the DataPath; ld=10000, ldi=10001, st=10010.
REQ-005 stop  in  1  halt request, sampled at instruction boundaries.
REQ-006 PCout, MARin, IncPC, Zin, PCin  out  1 each  fetch-path DataPath controls.
REQ-007 ram_read, ram_write, MDRin, MDRout, IRin  out  1 each  memory/MDR/IR controls.
REQ-008 Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowout  out  1 each  register-select and operand controls.
REQ-009 alu_add  out  1  selects ALU ADD for the Zin cycle.
REQ-010 run  out  1  high in every state except RESET_S and HALT.
REQ-011 state_out  out  5  encoding: RESET_S=0, T0..T7=1..8, HALT=9.

Function
REQ-012 Outputs SHALL be Moore (decoded from the state register only); every control is 0 unless listed for the current state.
REQ-013 RESET_S: all controls 0; next state T0.
REQ-014 T0: PCout, MARin, IncPC, Zin, alu_add; next T1.
REQ-015 T1: Zlowout, PCin, ram_read, MDRin; next T2.
REQ-016 T2: MDRout, IRin; next T3.
REQ-017 T3 (ld/ldi/st): Grb, BAout, Yin; ir_opcode is sampled in T3; unrecognised opcode asserts nothing in T3 and goes to the boundary (REQ-022).
REQ-018 T4 (ld/ldi/st): Cout, Zin, alu_add; next T5.
REQ-019 ld: T5 Zlowout, MARin; T6 ram_read, MDRin; T7 MDRout, Gra, Rin; then boundary. 8 cycles total.
REQ-020 ldi: T5 Zlowout, Gra, Rin; then boundary. 6 cycles total.
REQ-021 st: T5 Zlowout, MARin; T6 Gra, Rout, MDRin; T7 MDRout, ram_write; then boundary. 8 cycles total.
REQ-022 Boundary: next state is HALT if stop=1 in the last cycle of the instruction, else T0.
REQ-023 HALT: all controls 0, run=0; held until clear.
REQ-024 No two bus drivers (PCout, Zlowout, MDRout, Rout, Cout) SHALL be asserted in the same state.
REQ-025 The opcode latched at T3 SHALL govern T4..T7 even if ir_opcode changes afterwards.

Reset
REQ-026 clear=1 SHALL force RESET_S immediately (asynchronous), from any state including mid-instruction; all controls 0 within the same delta; state_out=0.
REQ-027 The first rising edge with clear=0 SHALL move RESET_S to T0.

Configuration
REQ-028 Macro MEM_WAIT_EN. Defined: input mem_ready (1 bit) exists; T1, ld T6 and st T7 hold while mem_ready=0 with their controls held asserted, and advance on the edge where mem_ready=1. Undefined: no mem_ready port; those states last exactly one cycle.

Verification
REQ-029 Reset: clear pulses mid-T5 of ld -> state_out=0 and all controls 0 immediately; T0 (state_out=1) one edge after release.
REQ-030 ld (ir_opcode=10000): from T0, state_out sequence 1..8 then 1; MARin high in T0 and T5 only; Gra&Rin only in T7.
REQ-031 ldi (10001): sequence 1..6 then 1; Gra&Rin in T5; ram_read only in T1.
REQ-032 st (10010): ram_write asserted exactly in T7 (state_out=8); Rout&Gra in T6.
REQ-033 Unknown opcode (00000) plus stop=1 on that final T3 -> HALT (state_out=9), run=0, held 10 cycles.
REQ-034 With MEM_WAIT_EN: mem_ready low 3 cycles during T1 -> state_out=2 for 4 cycles, ram_read and MDRin high throughout.

Source files
------------

// File: rtl/load_store_control_if.sv
// Control bundle between the load/store sequencer and the DataPath.
// MEM_WAIT_EN adds the mem_ready handshake from memory.
interface load_store_control_if;
    logic [4:0] ir_opcode;
    logic       stop;
`ifdef MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic PCout, MARin, IncPC, Zin, PCin;
    logic ram_read, ram_write, MDRin, MDRout, IRin;
    logic Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowout;
    logic alu_add;
    logic run;
    logic [4:0] state_out;

    modport master (
`ifdef MEM_WAIT_EN
        input  mem_ready,
`endif
        input  ir_opcode, stop,
        output PCout, MARin, IncPC, Zin, PCin,
        output ram_read, ram_write, MDRin, MDRout, IRin,
        output Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowout,
        output alu_add, run, state_out
    );

    modport slave (
`ifdef MEM_WAIT_EN
        output mem_ready,
`endif
        output ir_opcode, stop,
        input  PCout, MARin, IncPC, Zin, PCin,
        input  ram_read, ram_write, MDRin, MDRout, IRin,
        input  Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowout,
        input  alu_add, run, state_out
    );
endinterface

// File: rtl/load_store_control.sv
// Fetch/execute sequencer for ld, ldi and st with a stop-controlled halt.
// Defining MEM_WAIT_EN makes the memory-access states wait on mem_ready.
module load_store_control (
    input logic clock,
    input logic clear,
    load_store_control_if.master bus
);
    typedef enum logic [4:0] {
        RESET_S = 5'd0,
        T0      = 5'd1,
        T1      = 5'd2,
        T2      = 5'd3,
        T3      = 5'd4,
        T4      = 5'd5,
        T5      = 5'd6,
        T6      = 5'd7,
        T7      = 5'd8,
        HALT    = 5'd9
    } state_t;

    localparam logic [4:0] OP_LD  = 5'b10000;
    localparam logic [4:0] OP_LDI = 5'b10001;
    localparam logic [4:0] OP_ST  = 5'b10010;

    state_t     state;
    state_t     next_state;
    state_t     boundary;
    logic [4:0] opcode_q;
    logic       known_op;
    logic       mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    // The opcode is captured on leaving T3 so later states ignore IR changes.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= RESET_S;
            opcode_q <= 5'b00000;
        end else begin
            state <= next_state;
            if (state == T3) begin
                opcode_q <= bus.ir_opcode;
            end
        end
    end

    always_comb begin
        known_op   = (bus.ir_opcode == OP_LD) || (bus.ir_opcode == OP_LDI) ||
                     (bus.ir_opcode == OP_ST);
        boundary   = bus.stop ? HALT : T0;
        next_state = state;

        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Zin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.ram_read = 1'b0;
        bus.ram_write = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.BAout    = 1'b0;
        bus.Yin      = 1'b0;
        bus.Cout     = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.alu_add  = 1'b0;
        bus.run      = (state != RESET_S) && (state != HALT);
        bus.state_out = state;

        case (state)
            RESET_S: next_state = T0;
            T0: begin
                bus.PCout   = 1'b1;
                bus.MARin   = 1'b1;
                bus.IncPC   = 1'b1;
                bus.Zin     = 1'b1;
                bus.alu_add = 1'b1;
                next_state  = T1;
            end
            T1: begin
                bus.Zlowout  = 1'b1;
                bus.PCin     = 1'b1;
                bus.ram_read = 1'b1;
                bus.MDRin    = 1'b1;
                next_state   = mem_ok ? T2 : T1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                next_state = T3;
            end
            // IR was loaded at the end of T2, so T3 decodes the live opcode.
            T3: begin
                if (known_op) begin
                    bus.Grb    = 1'b1;
                    bus.BAout  = 1'b1;
                    bus.Yin    = 1'b1;
                    next_state = T4;
                end else begin
                    next_state = boundary;
                end
            end
            T4: begin
                bus.Cout    = 1'b1;
                bus.Zin     = 1'b1;
                bus.alu_add = 1'b1;
                next_state  = T5;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (opcode_q == OP_LDI) begin
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                    next_state = boundary;
                end else begin
                    bus.MARin  = 1'b1;
                    next_state = T6;
                end
            end
            T6: begin
                bus.MDRin = 1'b1;
                if (opcode_q == OP_ST) begin
                    bus.Gra    = 1'b1;
                    bus.Rout   = 1'b1;
                    next_state = T7;
                end else begin
                    bus.ram_read = 1'b1;
                    next_state   = mem_ok ? T7 : T6;
                end
            end
            T7: begin
                bus.MDRout = 1'b1;
                if (opcode_q == OP_ST) begin
                    bus.ram_write = 1'b1;
                    next_state    = mem_ok ? boundary : T7;
                end else begin
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                    next_state = boundary;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = RESET_S;
        endcase
    end
endmodule

// File: tb/tb_load_store_control.sv
// Scoreboard bench for load_store_control: per-cycle expected state and
// control vectors are queued per instruction and compared as the FSM steps.
module tb_load_store_control;
    localparam logic [19:0] M_PCOUT   = 20'h00001;
    localparam logic [19:0] M_MARIN   = 20'h00002;
    localparam logic [19:0] M_INCPC   = 20'h00004;
    localparam logic [19:0] M_ZIN     = 20'h00008;
    localparam logic [19:0] M_PCIN    = 20'h00010;
    localparam logic [19:0] M_RDR     = 20'h00020;
    localparam logic [19:0] M_WR      = 20'h00040;
    localparam logic [19:0] M_MDRIN   = 20'h00080;
    localparam logic [19:0] M_MDROUT  = 20'h00100;
    localparam logic [19:0] M_IRIN    = 20'h00200;
    localparam logic [19:0] M_GRA     = 20'h00400;
    localparam logic [19:0] M_GRB     = 20'h00800;
    localparam logic [19:0] M_RIN     = 20'h01000;
    localparam logic [19:0] M_ROUT    = 20'h02000;
    localparam logic [19:0] M_BAOUT   = 20'h04000;
    localparam logic [19:0] M_YIN     = 20'h08000;
    localparam logic [19:0] M_COUT    = 20'h10000;
    localparam logic [19:0] M_ZLOWOUT = 20'h20000;
    localparam logic [19:0] M_ADD     = 20'h40000;
    localparam logic [19:0] M_RUN     = 20'h80000;

    localparam logic [4:0] OP_LD  = 5'b10000;
    localparam logic [4:0] OP_LDI = 5'b10001;
    localparam logic [4:0] OP_ST  = 5'b10010;
    localparam logic [4:0] OP_BAD = 5'b00000;

    logic clock;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    int   wait_left = 0;
    logic [24:0] exp_q[$];
    logic [19:0] obs_ctrl;

    load_store_control_if bus_if ();

    load_store_control dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obs_ctrl = {bus_if.run, bus_if.alu_add, bus_if.Zlowout, bus_if.Cout,
                       bus_if.Yin, bus_if.BAout, bus_if.Rout, bus_if.Rin,
                       bus_if.Grb, bus_if.Gra, bus_if.IRin, bus_if.MDRout,
                       bus_if.MDRin, bus_if.ram_write, bus_if.ram_read,
                       bus_if.PCin, bus_if.Zin, bus_if.IncPC, bus_if.MARin,
                       bus_if.PCout};

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual,
                     expected, $time);
        end
    endtask

    task automatic push_exp(input logic [4:0] st, input logic [19:0] ctrl);
        logic [19:0] c;
        c = ctrl;
        if (st >= 5'd1 && st <= 5'd8) c = c | M_RUN;
        exp_q.push_back({st, c});
    endtask

    task automatic push_fetch(input logic [4:0] op);
        push_exp(5'd1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_ADD);
        push_exp(5'd2, M_ZLOWOUT | M_PCIN | M_RDR | M_MDRIN);
        for (int i = 0; i < wait_left; i++)
            push_exp(5'd2, M_ZLOWOUT | M_PCIN | M_RDR | M_MDRIN);
        push_exp(5'd3, M_MDROUT | M_IRIN);
        if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
            push_exp(5'd4, M_GRB | M_BAOUT | M_YIN);
            push_exp(5'd5, M_COUT | M_ZIN | M_ADD);
        end else begin
            push_exp(5'd4, 20'h0);
        end
    endtask

    task automatic push_exec(input logic [4:0] op);
        case (op)
            OP_LD: begin
                push_exp(5'd6, M_ZLOWOUT | M_MARIN);
                push_exp(5'd7, M_RDR | M_MDRIN);
                push_exp(5'd8, M_MDROUT | M_GRA | M_RIN);
            end
            OP_LDI: push_exp(5'd6, M_ZLOWOUT | M_GRA | M_RIN);
            OP_ST: begin
                push_exp(5'd6, M_ZLOWOUT | M_MARIN);
                push_exp(5'd7, M_GRA | M_ROUT | M_MDRIN);
                push_exp(5'd8, M_MDROUT | M_WR);
            end
            default: ;
        endcase
    endtask

    // One cycle: drive memory readiness, compare against the scoreboard, tick.
    task automatic step_cycle();
        logic [24:0] e;
        e = exp_q.pop_front();
`ifdef MEM_WAIT_EN
        if (e[24:20] == 5'd2 && wait_left > 0) begin
            bus_if.mem_ready = 1'b0;
            wait_left--;
        end else begin
            bus_if.mem_ready = 1'b1;
        end
`endif
        #1;
        check_output("state", 32'(bus_if.state_out), 32'(e[24:20]));
        check_output("ctrl", 32'(obs_ctrl), 32'(e[19:0]));
        check_output("bus_drivers",
                     32'($countones({bus_if.PCout, bus_if.Zlowout, bus_if.MDRout,
                                     bus_if.Rout, bus_if.Cout}) <= 1), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [4:0] op, input logic stp,
                                  input logic scramble);
        bus_if.ir_opcode = op;
        bus_if.stop      = stp;
        push_fetch(op);
        push_exec(op);
        while (exp_q.size() > 0) begin
            if (scramble && exp_q[0][24:20] == 5'd5) bus_if.ir_opcode = OP_BAD;
            step_cycle();
        end
    endtask

    initial begin
        clear            = 1'b1;
        bus_if.ir_opcode = 5'b0;
        bus_if.stop      = 1'b0;
`ifdef MEM_WAIT_EN
        bus_if.mem_ready = 1'b1;
`endif
        #3;
        check_output("reset_state", 32'(bus_if.state_out), 32'd0);
        check_output("reset_ctrl", 32'(obs_ctrl), 32'd0);
        @(posedge clock);
        #1;
        check_output("reset_hold", 32'(bus_if.state_out), 32'd0);
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        #1;

        apply_stimulus(OP_LD, 1'b0, 1'b0);
        apply_stimulus(OP_LDI, 1'b0, 1'b0);
        apply_stimulus(OP_ST, 1'b0, 1'b0);
        apply_stimulus(OP_LD, 1'b0, 1'b1);
        apply_stimulus(OP_ST, 1'b0, 1'b1);
        apply_stimulus(OP_BAD, 1'b0, 1'b0);
`ifdef MEM_WAIT_EN
        wait_left = 3;
        apply_stimulus(OP_LD, 1'b0, 1'b0);
`endif

        // Abort an ld in the middle of T5 with an asynchronous clear.
        bus_if.ir_opcode = OP_LD;
        bus_if.stop      = 1'b0;
        push_fetch(OP_LD);
        while (exp_q.size() > 0) step_cycle();
        check_output("pre_clear_t5", 32'(bus_if.state_out), 32'd6);
        #2;
        clear = 1'b1;
        #1;
        check_output("async_state", 32'(bus_if.state_out), 32'd0);
        check_output("async_ctrl", 32'(obs_ctrl), 32'd0);
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock);
        #1;
        check_output("release_t0", 32'(bus_if.state_out), 32'd1);

        bus_if.ir_opcode = OP_BAD;
        bus_if.stop      = 1'b1;
        push_fetch(OP_BAD);
        for (int i = 0; i < 10; i++) push_exp(5'd9, 20'h0);
        while (exp_q.size() > 0) step_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
